// File: rtl/test_result_monitor.sv
// Bus-snooping pass/fail monitor: captures stores to RESULT_ADDR, ends the run on timeout and
// compares against the expected byte. Define RESULT_TRAP_EN to also end runs on a JMP-to-self fetch loop.
module test_result_monitor #(
    parameter logic [15:0] RESULT_ADDR    = 16'h0042,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd100,
    parameter int          TRAP_REPEAT    = 3
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    input  logic        memwrite,
    input  logic        fetch,
    input  logic        start,
    input  logic [7:0]  expected,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        nowrite,
    output logic        trapped,
    output logic [7:0]  result,
    output logic [15:0] cycles,
    output logic [7:0]  wcount
);

    typedef enum logic [1:0] {IDLE, ARMED, CHECK, FINISHED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  result_q, result_d;
    logic [15:0] cycles_q, cycles_d;
    logic [7:0]  wcount_q, wcount_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        nowrite_q, nowrite_d;
    logic        trapped_q, trapped_d;
    logic        trap_hit;

`ifdef RESULT_TRAP_EN
    localparam logic [7:0] TRAP_N = 8'(TRAP_REPEAT);
    logic [15:0] faddr_q, faddr_d;
    logic [7:0]  fcnt_q, fcnt_d;

    // Counter is registered, so the run ends on the edge after the final repeated fetch.
    assign trap_hit = (state_q == ARMED) && (fcnt_q >= TRAP_N);
`else
    logic unused_trap;
    assign unused_trap = fetch ^ (TRAP_REPEAT < 2);
    assign trap_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        wcount_d  = wcount_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        nowrite_d = nowrite_q;
        trapped_d = trapped_q;
`ifdef RESULT_TRAP_EN
        faddr_d   = faddr_q;
        fcnt_d    = fcnt_q;
`endif
        case (state_q)
            IDLE, FINISHED: begin
                if (start) begin
                    state_d   = ARMED;
                    exp_d     = expected;
                    result_d  = 8'h00;
                    cycles_d  = 16'h0000;
                    wcount_d  = 8'h00;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    nowrite_d = 1'b0;
                    trapped_d = 1'b0;
`ifdef RESULT_TRAP_EN
                    faddr_d   = 16'h0000;
                    fcnt_d    = 8'h00;
`endif
                end
            end
            ARMED: begin
                cycles_d = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;
                if (memwrite && (address == RESULT_ADDR)) begin
                    result_d = data;
                    wcount_d = (wcount_q == 8'hFF) ? wcount_q : wcount_q + 8'd1;
                end
`ifdef RESULT_TRAP_EN
                if (fetch) begin
                    if (address == faddr_q) begin
                        fcnt_d = (fcnt_q >= TRAP_N) ? fcnt_q : fcnt_q + 8'd1;
                    end else begin
                        faddr_d = address;
                        fcnt_d  = 8'd1;
                    end
                end
`endif
                if (trap_hit || (cycles_q == TIMEOUT_CYCLES - 16'd1)) begin
                    state_d   = CHECK;
                    trapped_d = trap_hit;
                end
            end
            CHECK: begin
                state_d   = FINISHED;
                pass_d    = (wcount_q != 8'h00) && (result_q == exp_q);
                fail_d    = !((wcount_q != 8'h00) && (result_q == exp_q));
                nowrite_d = (wcount_q == 8'h00);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            exp_q     <= 8'h00;
            result_q  <= 8'h00;
            cycles_q  <= 16'h0000;
            wcount_q  <= 8'h00;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            nowrite_q <= 1'b0;
            trapped_q <= 1'b0;
`ifdef RESULT_TRAP_EN
            faddr_q   <= 16'h0000;
            fcnt_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            wcount_q  <= wcount_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            nowrite_q <= nowrite_d;
            trapped_q <= trapped_d;
`ifdef RESULT_TRAP_EN
            faddr_q   <= faddr_d;
            fcnt_q    <= fcnt_d;
`endif
        end
    end

    assign done    = (state_q == FINISHED);
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign nowrite = nowrite_q;
    assign trapped = trapped_q;
    assign result  = result_q;
    assign cycles  = cycles_q;
    assign wcount  = wcount_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: each scenario task drives a run and checks the verdict inline.
module tb_test_result_monitor;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data = 8'h00;
    logic        memwrite = 1'b0;
    logic        fetch = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  expected = 8'h00;
    logic        done, pass, fail, nowrite, trapped;
    logic [7:0]  result, wcount;
    logic [15:0] cycles;

    int n_chk = 0;
    int n_ok  = 0;
    int edge_n = 0;

    test_result_monitor dut (
        .ph1(ph1), .reset(reset), .address(address), .data(data), .memwrite(memwrite),
        .fetch(fetch), .start(start), .expected(expected), .done(done), .pass(pass),
        .fail(fail), .nowrite(nowrite), .trapped(trapped), .result(result),
        .cycles(cycles), .wcount(wcount)
    );

    always #5 ph1 = ~ph1;

    task automatic adv();
        @(posedge ph1);
        #1;
        edge_n++;
    endtask

    task automatic arm(input logic [7:0] exp_v);
        expected = exp_v;
        start = 1'b1;
        @(posedge ph1);
        #1;
        start = 1'b0;
        edge_n = 0;
    endtask

    task automatic idle_to(input int k);
        while (edge_n < k) adv();
    endtask

    task automatic store(input int k, input logic [15:0] a, input logic [7:0] d);
        idle_to(k - 1);
        address = a; data = d; memwrite = 1'b1;
        adv();
        memwrite = 1'b0; address = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_chk++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) $display("FAIL reset_flags: got done=%b pass=%b fail=%b want 000", done, pass, fail); else n_ok++;
        n_chk++; if (nowrite !== 1'b0 || trapped !== 1'b0) $display("FAIL reset_nowrite_trapped: got %b%b want 00", nowrite, trapped); else n_ok++;
        n_chk++; if (result !== 8'h00 || cycles !== 16'h0000 || wcount !== 8'h00) $display("FAIL reset_counts: got result=%h cycles=%0d wcount=%0d want 0/0/0", result, cycles, wcount); else n_ok++;
        @(negedge ph1);
        reset = 1'b0;
        adv(); adv();
        n_chk++; if (cycles !== 16'h0000 || done !== 1'b0) $display("FAIL idle_hold: got cycles=%0d done=%b want 0/0", cycles, done); else n_ok++;
    endtask

    task automatic test_basic_pass();
        arm(8'hA5);
        n_chk++; if (cycles !== 16'd0 || done !== 1'b0) $display("FAIL basic_arm: got cycles=%0d done=%b want 0/0", cycles, done); else n_ok++;
        store(40, 16'h0042, 8'hA5);
        n_chk++; if (cycles !== 16'd40 || result !== 8'hA5 || wcount !== 8'd1) $display("FAIL basic_mid: got cycles=%0d result=%h wcount=%0d want 40/a5/1", cycles, result, wcount); else n_ok++;
        idle_to(100);
        n_chk++; if (done !== 1'b0) $display("FAIL basic_not_done_100: got %b want 0", done); else n_ok++;
        adv();
        n_chk++; if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0) $display("FAIL basic_verdict: got done=%b pass=%b fail=%b want 110", done, pass, fail); else n_ok++;
        n_chk++; if (result !== 8'hA5 || wcount !== 8'd1 || cycles !== 16'd100 || nowrite !== 1'b0) $display("FAIL basic_final: got result=%h wcount=%0d cycles=%0d nowrite=%b want a5/1/100/0", result, wcount, cycles, nowrite); else n_ok++;
        adv(); adv();
        n_chk++; if (done !== 1'b1 || pass !== 1'b1 || cycles !== 16'd100) $display("FAIL basic_sticky: got done=%b pass=%b cycles=%0d want 1/1/100", done, pass, cycles); else n_ok++;
    endtask

    task automatic test_last_store_wins();
        arm(8'hA5);
        store(10, 16'h0042, 8'h11);
        store(20, 16'h0042, 8'h22);
        store(30, 16'h0042, 8'h5A);
        store(35, 16'h0043, 8'hFF);
        n_chk++; if (result !== 8'h5A || wcount !== 8'd3) $display("FAIL last_mid: got result=%h wcount=%0d want 5a/3", result, wcount); else n_ok++;
        idle_to(101);
        n_chk++; if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || nowrite !== 1'b0) $display("FAIL last_verdict: got done=%b fail=%b pass=%b nowrite=%b want 1100", done, fail, pass, nowrite); else n_ok++;
        n_chk++; if (result !== 8'h5A || wcount !== 8'd3) $display("FAIL last_final: got result=%h wcount=%0d want 5a/3", result, wcount); else n_ok++;
    endtask

    task automatic test_no_store_rearm();
        arm(8'h00);
        store(50, 16'h0041, 8'h00);
        idle_to(101);
        n_chk++; if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || nowrite !== 1'b1) $display("FAIL nostore_verdict: got done=%b fail=%b pass=%b nowrite=%b want 1101", done, fail, pass, nowrite); else n_ok++;
        n_chk++; if (result !== 8'h00 || wcount !== 8'd0) $display("FAIL nostore_result: got result=%h wcount=%0d want 00/0", result, wcount); else n_ok++;
        arm(8'hA5);
        n_chk++; if (done !== 1'b0 || fail !== 1'b0 || nowrite !== 1'b0 || cycles !== 16'd0) $display("FAIL rearm_clear: got done=%b fail=%b nowrite=%b cycles=%0d want 0/0/0/0", done, fail, nowrite, cycles); else n_ok++;
        store(50, 16'h0042, 8'hA5);
        idle_to(101);
        n_chk++; if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0) $display("FAIL rearm_pass: got done=%b pass=%b fail=%b want 110", done, pass, fail); else n_ok++;
    endtask

    task automatic test_boundary_store();
        arm(8'hA5);
        idle_to(19);
        expected = 8'h00; start = 1'b1;
        adv();
        start = 1'b0;
        n_chk++; if (cycles !== 16'd20) $display("FAIL midstart_cycles: got %0d want 20", cycles); else n_ok++;
        store(100, 16'h0042, 8'hA5);
        n_chk++; if (done !== 1'b0 || wcount !== 8'd1 || cycles !== 16'd100) $display("FAIL boundary_check_state: got done=%b wcount=%0d cycles=%0d want 0/1/100", done, wcount, cycles); else n_ok++;
        adv();
        n_chk++; if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || wcount !== 8'd1) $display("FAIL boundary_verdict: got done=%b pass=%b fail=%b wcount=%0d want 1/1/0/1", done, pass, fail, wcount); else n_ok++;
    endtask

    task automatic test_async_reset();
        arm(8'hA5);
        store(30, 16'h0042, 8'hA5);
        idle_to(50);
        #2 reset = 1'b1;
        #1;
        n_chk++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || result !== 8'h00 || cycles !== 16'd0 || wcount !== 8'd0) $display("FAIL async_reset: got done=%b pass=%b fail=%b result=%h cycles=%0d wcount=%0d want all 0", done, pass, fail, result, cycles, wcount); else n_ok++;
        #2 reset = 1'b0;
        adv(); adv();
        n_chk++; if (cycles !== 16'd0 || done !== 1'b0) $display("FAIL post_reset_idle: got cycles=%0d done=%b want 0/0", cycles, done); else n_ok++;
        arm(8'h3C);
        store(60, 16'h0042, 8'h3C);
        idle_to(100);
        n_chk++; if (done !== 1'b0) $display("FAIL post_reset_early: got done=%b want 0", done); else n_ok++;
        adv();
        n_chk++; if (done !== 1'b1 || pass !== 1'b1 || cycles !== 16'd100) $display("FAIL post_reset_run: got done=%b pass=%b cycles=%0d want 1/1/100", done, pass, cycles); else n_ok++;
    endtask

    task automatic test_trap();
        arm(8'hA5);
        store(30, 16'h0042, 8'hA5);
        fetch = 1'b1; address = 16'hF010;
        adv(); adv(); adv();
        fetch = 1'b0; address = 16'h0000;
        while (!done && edge_n < 120) adv();
        n_chk++; if (done !== 1'b1) $display("FAIL trap_done_timeout: got done=%b after %0d edges want 1", done, edge_n); else n_ok++;
        n_chk++; if (pass !== 1'b1 || fail !== 1'b0) $display("FAIL trap_verdict: got pass=%b fail=%b want 10", pass, fail); else n_ok++;
`ifdef RESULT_TRAP_EN
        n_chk++; if (trapped !== 1'b1 || edge_n !== 35 || cycles !== 16'd34) $display("FAIL trap_early: got trapped=%b edge=%0d cycles=%0d want 1/35/34", trapped, edge_n, cycles); else n_ok++;
`else
        n_chk++; if (trapped !== 1'b0 || edge_n !== 101 || cycles !== 16'd100) $display("FAIL trap_disabled: got trapped=%b edge=%0d cycles=%0d want 0/101/100", trapped, edge_n, cycles); else n_ok++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_last_store_wins();
        test_no_store_rearm();
        test_boundary_store();
        test_async_reset();
        test_trap();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
